// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: M-stage data-memory initiator, one valid/ready transaction per load/store.
// Optional feature macro DM_RESP_BYPASS_EN: forward the load response in its arrival cycle.
module dm_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        IM_stall,
  input  logic [4:0]  M_op,
  input  logic [2:0]  M_func3,
  input  logic [31:0] M_aluOut,
  input  logic [31:0] M_rs2_data,
  output logic        DM_stall,
  output logic [31:0] M_ReadData,
  output logic        dm_req_valid,
  input  logic        dm_req_ready,
  output logic        dm_req_we,
  output logic [31:0] dm_req_addr,
  output logic [3:0]  dm_req_wstrb,
  output logic [31:0] dm_req_wdata,
  input  logic        dm_resp_valid,
  input  logic [31:0] dm_resp_rdata
);

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        isLoad_q;
  logic [2:0]  func3_q;
  logic [1:0]  off_q;
  logic        reqWe_q;
  logic [31:0] reqAddr_q, reqWdata_q;
  logic [3:0]  reqWstrb_q;

  logic        isLoad, isStore, issue;
  logic [1:0]  off;
  logic [3:0]  stWstrb, issueWstrb;
  logic [31:0] stWdata, issueWdata, issueAddr, respFmt;

  function automatic logic [31:0] formatLoad(input logic [2:0] f3, input logic [1:0] o,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{o, 3'b000} +: 8];
    h = w[{o[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  formatLoad = {{24{b[7]}}, b};
      3'b001:  formatLoad = {{16{h[15]}}, h};
      3'b100:  formatLoad = {24'b0, b};
      3'b101:  formatLoad = {16'b0, h};
      default: formatLoad = w;
    endcase
  endfunction

  // Gating with rst keeps the port quiet while the pipeline registers are being cleared.
  assign isLoad  = !rst && (M_op == OP_LOAD);
  assign isStore = !rst && (M_op == OP_STORE);
  assign issue   = (state_q == IDLE) && (isLoad || isStore);
  assign off     = M_aluOut[1:0];
  assign respFmt = formatLoad(func3_q, off_q, dm_resp_rdata);

  always_comb begin
    stWstrb = 4'b1111;
    stWdata = M_rs2_data;
    case (M_func3[1:0])
      2'b00: begin
        stWstrb = 4'b0001 << off;
        stWdata = {4{M_rs2_data[7:0]}};
      end
      2'b01: begin
        stWstrb = 4'b0011 << {off[1], 1'b0};
        stWdata = {2{M_rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign issueAddr  = {M_aluOut[31:2], 2'b00};
  assign issueWstrb = isStore ? stWstrb : 4'b0000;
  assign issueWdata = isStore ? stWdata : 32'h0;

  always_comb begin
    dm_req_valid = 1'b0;
    dm_req_we    = 1'b0;
    dm_req_addr  = 32'h0;
    dm_req_wstrb = 4'b0000;
    dm_req_wdata = 32'h0;
    if (issue) begin
      dm_req_valid = 1'b1;
      dm_req_we    = isStore;
      dm_req_addr  = issueAddr;
      dm_req_wstrb = issueWstrb;
      dm_req_wdata = issueWdata;
    end else if (state_q == REQ) begin
      dm_req_valid = 1'b1;
      dm_req_we    = reqWe_q;
      dm_req_addr  = reqAddr_q;
      dm_req_wstrb = reqWstrb_q;
      dm_req_wdata = reqWdata_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    DM_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (isLoad || isStore) begin
          DM_stall = 1'b1;
          state_d  = dm_req_ready ? WAIT : REQ;
        end
      end
      REQ: begin
        DM_stall = 1'b1;
        if (dm_req_ready) state_d = WAIT;
      end
      WAIT: begin
        DM_stall = 1'b1;
        if (dm_resp_valid) begin
          if (isLoad_q) rdata_d = respFmt;
          state_d = DONE;
`ifdef DM_RESP_BYPASS_EN
          DM_stall = 1'b0;
          if (!IM_stall) state_d = IDLE;
`endif
        end
      end
      DONE: begin
        if (!IM_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DM_RESP_BYPASS_EN
  assign M_ReadData = (state_q == WAIT && dm_resp_valid && isLoad_q) ? respFmt : rdata_q;
`else
  assign M_ReadData = rdata_q;
`endif

  // The request is snapshotted at issue so it stays stable however long ready is held off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rdata_q    <= 32'h0;
      isLoad_q   <= 1'b0;
      func3_q    <= 3'b000;
      off_q      <= 2'b00;
      reqWe_q    <= 1'b0;
      reqAddr_q  <= 32'h0;
      reqWstrb_q <= 4'b0000;
      reqWdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (issue) begin
        isLoad_q   <= isLoad;
        func3_q    <= M_func3;
        off_q      <= off;
        reqWe_q    <= isStore;
        reqAddr_q  <= issueAddr;
        reqWstrb_q <= issueWstrb;
        reqWdata_q <= issueWdata;
      end
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed transactions against a transaction-level model of dm_access_ctrl.
module tb_dm_access_ctrl;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] OP_OTHER = 5'b01100;
`ifdef DM_RESP_BYPASS_EN
  localparam int STALL_MIN = 1;
`else
  localparam int STALL_MIN = 2;
`endif

  logic        clk, rst, IM_stall;
  logic [4:0]  M_op;
  logic [2:0]  M_func3;
  logic [31:0] M_aluOut, M_rs2_data;
  logic        DM_stall;
  logic [31:0] M_ReadData;
  logic        dm_req_valid, dm_req_ready, dm_req_we;
  logic [31:0] dm_req_addr, dm_req_wdata;
  logic [3:0]  dm_req_wstrb;
  logic        dm_resp_valid;
  logic [31:0] dm_resp_rdata;

  dm_access_ctrl dut (
    .clk(clk), .rst(rst), .IM_stall(IM_stall),
    .M_op(M_op), .M_func3(M_func3), .M_aluOut(M_aluOut), .M_rs2_data(M_rs2_data),
    .DM_stall(DM_stall), .M_ReadData(M_ReadData),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_we(dm_req_we),
    .dm_req_addr(dm_req_addr), .dm_req_wstrb(dm_req_wstrb), .dm_req_wdata(dm_req_wdata),
    .dm_resp_valid(dm_resp_valid), .dm_resp_rdata(dm_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatch = 0;
  int hsCount   = 0;
  int stallCnt  = 0;
  int expHs     = 0;
  int lastStall = 0;
  bit checkEn   = 1'b0;

  logic        expStall, expValid, expWe;
  logic [31:0] expAddr, expWdata, expRd;
  logic [3:0]  expWstrb;
  logic [31:0] modelRd = 32'h0;
  logic [31:0] lastAddr, lastWdata;
  logic [3:0]  lastWstrb;
  logic        lastWe;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Load result from byte arithmetic on the response word.
  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] word);
    int off, base, b, h;
    off  = int'(addr[1:0]);
    base = (off / 2) * 2;
    b    = int'((word >> (8 * off)) & 32'h0000_00FF);
    h    = int'((word >> (8 * base)) & 32'h0000_FFFF);
    case (f3)
      3'b000:  return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'b001:  return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return word;
    endcase
  endfunction

  // Store lanes: an aligned window of size bytes, each lane carrying rs2 byte (lane mod size).
  task automatic modelStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                            output logic [3:0] ws, output logic [31:0] wd);
    int size, start;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    start = (int'(addr[1:0]) / size) * size;
    for (int i = 0; i < 4; i++) begin
      ws[i]        = (i >= start) && (i < start + size);
      wd[8*i +: 8] = rs2[8*(i % size) +: 8];
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dm_req_valid && dm_req_ready) begin
      hsCount++;
      lastAddr  = dm_req_addr;
      lastWe    = dm_req_we;
      lastWstrb = dm_req_wstrb;
      lastWdata = dm_req_wdata;
    end
    if (DM_stall) stallCnt++;
    if (checkEn) begin
      checkOutput("DM_stall", 32'(DM_stall), 32'(expStall));
      checkOutput("req_valid", 32'(dm_req_valid), 32'(expValid));
      checkOutput("req_we", 32'(dm_req_we), 32'(expWe));
      checkOutput("req_addr", dm_req_addr, expAddr);
      checkOutput("req_wstrb", 32'(dm_req_wstrb), 32'(expWstrb));
      checkOutput("req_wdata", dm_req_wdata, expWdata);
      checkOutput("M_ReadData", M_ReadData, expRd);
    end
  end

  // One M-stage instruction: ready after r cycles, response d cycles after acceptance,
  // IM_stall held for h cycles from the response, optionally also during REQ/WAIT.
  task automatic applyStimulus(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] rs2, input logic [31:0] word,
                               input int r, input int d, input int h,
                               input bit imDuring, input bit spurious);
    logic        ld;
    logic [3:0]  ws;
    logic [31:0] wd, newRd;
    int          respC, lastC, stallBase;
    ld = (op == OP_LOAD);
    modelStore(f3, addr, rs2, ws, wd);
    newRd = ld ? modelLoad(f3, addr, word) : modelRd;
    respC = r + 1 + d;
`ifdef DM_RESP_BYPASS_EN
    lastC = (h > 0) ? respC + h + 1 : respC;
`else
    lastC = (h > 0) ? respC + h + 1 : respC + 1;
`endif
    stallBase  = stallCnt;
    expHs++;
    M_op       = op;
    M_func3    = f3;
    M_aluOut   = addr;
    M_rs2_data = rs2;
    for (int c = 0; c <= lastC; c++) begin
      dm_req_ready  = (c == r);
      dm_resp_valid = (c == respC) || (spurious && c <= r);
      dm_resp_rdata = (c == respC) ? word : 32'h1357_9BDF;
      IM_stall      = (imDuring && c >= 1 && c < respC) || (h > 0 && c >= respC && c <= respC + h);
      expValid      = (c <= r);
      expWe         = (c <= r) && !ld;
      expAddr       = (c <= r) ? (addr & 32'hFFFF_FFFC) : 32'h0;
      expWstrb      = (c <= r && !ld) ? ws : 4'b0000;
      expWdata      = (c <= r && !ld) ? wd : 32'h0;
`ifdef DM_RESP_BYPASS_EN
      expStall      = (c < respC);
      expRd         = (c >= respC) ? newRd : modelRd;
`else
      expStall      = (c <= respC);
      expRd         = (c > respC) ? newRd : modelRd;
`endif
      @(posedge clk); #1;
    end
    modelRd       = newRd;
    lastStall     = stallCnt - stallBase;
    dm_req_ready  = 1'b0;
    dm_resp_valid = 1'b0;
    IM_stall      = 1'b0;
  endtask

  task automatic idleCycles(input int n, input bit imSt, input bit spurious);
    for (int c = 0; c < n; c++) begin
      M_op          = OP_OTHER;
      M_func3       = 3'($urandom_range(0, 7));
      M_aluOut      = $urandom;
      M_rs2_data    = $urandom;
      IM_stall      = imSt;
      dm_req_ready  = 1'($urandom_range(0, 1));
      dm_resp_valid = spurious;
      dm_resp_rdata = $urandom;
      expStall = 1'b0; expValid = 1'b0; expWe = 1'b0;
      expAddr  = 32'h0; expWstrb = 4'b0000; expWdata = 32'h0; expRd = modelRd;
      @(posedge clk); #1;
    end
    IM_stall      = 1'b0;
    dm_resp_valid = 1'b0;
  endtask

  initial begin
    int hsBase;
    rst = 1'b1; IM_stall = 1'b0;
    M_op = OP_LOAD; M_func3 = 3'b010; M_aluOut = 32'h100; M_rs2_data = 32'h11;
    dm_req_ready = 1'b0; dm_resp_valid = 1'b0; dm_resp_rdata = 32'h0;
    #3;
    checkOutput("reset_stall", 32'(DM_stall), 32'h0);
    checkOutput("reset_valid", 32'(dm_req_valid), 32'h0);
    checkOutput("reset_we", 32'(dm_req_we), 32'h0);
    checkOutput("reset_wstrb", 32'(dm_req_wstrb), 32'h0);
    checkOutput("reset_readdata", M_ReadData, 32'h0);
    @(posedge clk); #1;
    M_op = OP_OTHER;
    rst = 1'b0;
    checkEn = 1'b1;
    idleCycles(2, 1'b0, 1'b0);

    applyStimulus(OP_LOAD, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 1'b0, 1'b0);
    checkOutput("lw_stall_cycles", 32'(lastStall), 32'(STALL_MIN));
    checkOutput("lw_addr", lastAddr, 32'h100);
    checkOutput("lw_we", 32'(lastWe), 32'h0);
    checkOutput("lw_wstrb", 32'(lastWstrb), 32'h0);
    checkOutput("lw_data", M_ReadData, 32'hDEAD_BEEF);

    applyStimulus(OP_LOAD, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 0, 1'b0, 1'b0);
    checkOutput("lb_data", M_ReadData, 32'hFFFF_FF80);
    applyStimulus(OP_LOAD, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 0, 1'b0, 1'b0);
    checkOutput("lbu_data", M_ReadData, 32'h0000_0080);
    applyStimulus(OP_LOAD, 3'b001, 32'h102, 32'h0, 32'h80FF_1234, 0, 0, 0, 1'b0, 1'b0);
    checkOutput("lh_data", M_ReadData, 32'hFFFF_80FF);
    applyStimulus(OP_LOAD, 3'b101, 32'h102, 32'h0, 32'h80FF_1234, 0, 0, 0, 1'b0, 1'b0);
    idleCycles(1, 1'b0, 1'b1);

    applyStimulus(OP_STORE, 3'b000, 32'h201, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 0, 0, 1'b0, 1'b0);
    checkOutput("sb_wstrb", 32'(lastWstrb), 32'h2);
    checkOutput("sb_wdata", lastWdata, 32'hA5A5_A5A5);
    applyStimulus(OP_STORE, 3'b001, 32'h202, 32'h1234_BEEF, 32'hFFFF_FFFF, 0, 0, 0, 1'b0, 1'b0);
    checkOutput("sh_wstrb", 32'(lastWstrb), 32'hC);
    checkOutput("sh_wdata", lastWdata, 32'hBEEF_BEEF);
    applyStimulus(OP_STORE, 3'b010, 32'h30E, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 1, 0, 1'b0, 1'b0);
    checkOutput("sw_addr", lastAddr, 32'h30C);
    checkOutput("sw_wstrb", 32'(lastWstrb), 32'hF);

    hsBase = hsCount;
    applyStimulus(OP_LOAD, 3'b010, 32'h404, 32'h0, 32'h0A0B_0C0D, 3, 4, 0, 1'b0, 1'b1);
    checkOutput("delayed_stall_cycles", 32'(lastStall), 32'(STALL_MIN + 7));
    checkOutput("delayed_handshakes", 32'(hsCount - hsBase), 32'h1);

    applyStimulus(OP_LOAD, 3'b001, 32'h101, 32'h0, 32'h7FFF_8001, 0, 0, 5, 1'b0, 1'b0);
    checkOutput("lh_misaligned_data", M_ReadData, 32'hFFFF_8001);
    applyStimulus(OP_LOAD, 3'b100, 32'h102, 32'h0, 32'h11C3_5577, 2, 1, 2, 1'b1, 1'b0);
    applyStimulus(OP_STORE, 3'b000, 32'h0FF, 32'h0000_0042, 32'h0000_0000, 0, 2, 3, 1'b1, 1'b0);
    idleCycles(3, 1'b1, 1'b1);

    checkEn = 1'b0;
    M_op = OP_LOAD; M_func3 = 3'b010; M_aluOut = 32'h500;
    dm_req_ready = 1'b1; dm_resp_valid = 1'b0; IM_stall = 1'b0;
    expHs++;
    @(posedge clk); #1;
    dm_req_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_mid_valid", 32'(dm_req_valid), 32'h0);
    checkOutput("rst_mid_stall", 32'(DM_stall), 32'h0);
    checkOutput("rst_mid_readdata", M_ReadData, 32'h0);
    M_op = OP_OTHER;
    #1 rst = 1'b0;
    modelRd = 32'h0;
    @(posedge clk); #1;
    checkEn = 1'b1;
    applyStimulus(OP_LOAD, 3'b010, 32'h600, 32'h0, 32'h600D_CAFE, 0, 0, 0, 1'b0, 1'b0);
    checkOutput("post_reset_data", M_ReadData, 32'h600D_CAFE);
    idleCycles(2, 1'b0, 1'b0);
    checkEn = 1'b0;
    checkOutput("handshake_total", 32'(hsCount), 32'(expHs));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
